// File: rtl/riscv_vec_pkg.sv
// Shared constants, width helpers and FSM encodings for the vector register file.
package riscv_vec_pkg;

  function automatic int addr_width(input int num_regs);
    return $clog2(num_regs);
  endfunction

  // VL must be able to hold NUM_LANES itself, hence the extra bit.
  function automatic int vl_width(input int num_lanes);
    return $clog2(num_lanes) + 1;
  endfunction

  localparam int NUM_LANES_DEF = 8;
  localparam int ELEM_W_DEF    = 32;
  localparam int NUM_REGS_DEF  = 32;
  localparam int VL_W          = vl_width(NUM_LANES_DEF);
  localparam int RADDR_W       = addr_width(NUM_REGS_DEF);

  typedef enum logic [0:0] {
    VRF_IDLE  = 1'b0,
    VRF_SCRUB = 1'b1
  } vrf_state_e;

endpackage

// File: rtl/riscv_core_dpath_vec_regfile_scrub_if.sv
// Read/write/VL/scrub signal bundle of the vector register file.
interface riscv_core_dpath_vec_regfile_scrub_if
  import riscv_vec_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int ELEM_W    = ELEM_W_DEF,
  parameter int NUM_REGS  = NUM_REGS_DEF
) ();

  localparam int DATA_W = NUM_LANES * ELEM_W;
  localparam int ADDR_W = addr_width(NUM_REGS);
  localparam int VLEN_W = vl_width(NUM_LANES);

  logic [ADDR_W-1:0]    raddr0;
  logic [DATA_W-1:0]    rdata0;
  logic [ADDR_W-1:0]    raddr1;
  logic [DATA_W-1:0]    rdata1;
  logic                 wen_p;
  logic [ADDR_W-1:0]    waddr_p;
  logic [DATA_W-1:0]    wdata_p;
  logic [NUM_LANES-1:0] wmask_p;
  logic                 wvlen_p;
  logic [31:0]          wvl_p;
  logic                 clear_p;
  logic [VLEN_W-1:0]    vl;
  logic                 busy;

  modport master (
    output raddr0, raddr1, wen_p, waddr_p, wdata_p, wmask_p, wvlen_p, wvl_p, clear_p,
    input  rdata0, rdata1, vl, busy
  );

  modport slave (
    input  raddr0, raddr1, wen_p, waddr_p, wdata_p, wmask_p, wvlen_p, wvl_p, clear_p,
    output rdata0, rdata1, vl, busy
  );

endinterface

// File: rtl/riscv_core_dpath_vec_regfile_scrub_ctl.sv
// Scrub controller: walks registers 1..NUM_REGS-1 writing zero, one per cycle.
module riscv_core_dpath_vec_regfile_scrub_ctl
  import riscv_vec_pkg::*;
#(
  parameter  int NUM_REGS = NUM_REGS_DEF,
  localparam int ADDR_W   = addr_width(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  output logic              scrub_we,
  output logic [ADDR_W-1:0] scrub_addr,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

  vrf_state_e        state;
  logic [ADDR_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= VRF_SCRUB;
      cnt   <= FIRST;
      busy  <= 1'b1;
    end else begin
      case (state)
        VRF_IDLE: begin
          if (clear) begin
            state <= VRF_SCRUB;
            cnt   <= FIRST;
            busy  <= 1'b1;
          end
        end
        VRF_SCRUB: begin
          if (clear) begin
            cnt <= FIRST;
          end else if (cnt == LAST) begin
            state <= VRF_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + FIRST;
          end
        end
        default: begin
          state <= VRF_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign scrub_we   = (state == VRF_SCRUB);
  assign scrub_addr = cnt;

endmodule

// File: rtl/riscv_core_dpath_vec_regfile_scrub.sv
// Vector register file: 2 combinational read ports, 1 masked/VL-limited write port,
// saturating VL register, scrub-on-reset and optional write-to-read bypass.
module riscv_core_dpath_vec_regfile_scrub
  import riscv_vec_pkg::*;
#(
  parameter int NUM_LANES = NUM_LANES_DEF,
  parameter int ELEM_W    = ELEM_W_DEF,
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int BYPASS    = 0
) (
  input logic clk,
  input logic reset,
  riscv_core_dpath_vec_regfile_scrub_if.slave bus
);

  localparam int DATA_W = NUM_LANES * ELEM_W;
  localparam int ADDR_W = addr_width(NUM_REGS);
  localparam int VLEN_W = vl_width(NUM_LANES);
  localparam logic [31:0]       LANES_32 = 32'(NUM_LANES);
  localparam logic [VLEN_W-1:0] VL_MAX   = VLEN_W'(NUM_LANES);

  logic                 busy;
  logic                 scrub_we;
  logic [ADDR_W-1:0]    scrub_addr;
  logic [VLEN_W-1:0]    vl_q;
  logic                 wr_acc;
  logic [NUM_LANES-1:0] elem_en;
  logic [DATA_W-1:0]    mem [NUM_REGS];
  logic [ADDR_W-1:0]    raddr [2];
  logic [DATA_W-1:0]    rdata [2];

  riscv_core_dpath_vec_regfile_scrub_ctl #(
    .NUM_REGS (NUM_REGS)
  ) u_ctl (
    .clk        (clk),
    .reset      (reset),
    .clear      (bus.clear_p),
    .scrub_we   (scrub_we),
    .scrub_addr (scrub_addr),
    .busy       (busy)
  );

  // A clear request wins over a same-cycle write; register 0 is never stored.
  assign wr_acc = bus.wen_p && !busy && !bus.clear_p && (bus.waddr_p != '0);

  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    elem_en = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      elem_en[i] = wr_acc && bus.wmask_p[i] && (VLEN_W'(i) < vl_q);
    end
  end

  // Full 32-bit compare before narrowing, so large requests saturate rather than wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vl_q <= VL_MAX;
    end else if (bus.wvlen_p) begin
      vl_q <= (bus.wvl_p >= LANES_32) ? VL_MAX : VLEN_W'(bus.wvl_p);
    end
  end

  // NOTE: the array has no reset; the scrub FSM zeroes it after reset instead.
  always_ff @(posedge clk) begin
    if (scrub_we) begin
      mem[scrub_addr] <= '0;
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      if (elem_en[i]) begin
        mem[bus.waddr_p][i*ELEM_W +: ELEM_W] <= bus.wdata_p[i*ELEM_W +: ELEM_W];
      end
    end
  end

  function automatic logic [DATA_W-1:0] merge(
    input logic [DATA_W-1:0]    stored,
    input logic [DATA_W-1:0]    wdata,
    input logic [NUM_LANES-1:0] en
  );
    logic [DATA_W-1:0] result;
    result = stored;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (en[i]) begin
        result[i*ELEM_W +: ELEM_W] = wdata[i*ELEM_W +: ELEM_W];
      end
    end
    return result;
  endfunction

  assign raddr[0] = bus.raddr0;
  assign raddr[1] = bus.raddr1;

  // elem_en is all-zero unless a write is accepted, so the merge is a no-op otherwise.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = mem[raddr[p]];
      if ((BYPASS != 0) && (raddr[p] == bus.waddr_p)) begin
        rdata[p] = merge(rdata[p], bus.wdata_p, elem_en);
      end
      if (busy || (raddr[p] == '0)) begin
        rdata[p] = '0;
      end
    end
  end

  assign bus.rdata0 = rdata[0];
  assign bus.rdata1 = rdata[1];
  assign bus.vl     = vl_q;
  assign bus.busy   = busy;

endmodule
